// File: rtl/ex3_pkg.sv
// ex3_pkg: shared Excess-3 constants and decoder FSM state type
package ex3_pkg;
  localparam logic [3:0] EX3_OFFSET  = 4'd3;
  localparam logic [3:0] EX3_MIN     = 4'h3;
  localparam logic [3:0] EX3_MAX     = 4'hC;
  localparam logic [3:0] BCD_INVALID = 4'hF;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/ex_3tobcd.sv
// ex_3tobcd: combinational single-digit Excess-3 to BCD decoder
module ex_3tobcd
  import ex3_pkg::*;
(
  input  logic [3:0] X,
  output logic [3:0] B,
  output logic       err
);
  always_comb begin
    err = (X < EX3_MIN) || (X > EX3_MAX);
    B   = err ? BCD_INVALID : X - EX3_OFFSET;
  end
endmodule

// File: rtl/ex_3tobcd_serial.sv
// ex_3tobcd_serial: digit-serial Excess-3 to packed-BCD decoder, one digit per clock
module ex_3tobcd_serial
  import ex3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_b,
  output logic [DIGITS-1:0]   out_err_mask,
  output logic                out_err
);
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] sh_q, sh_d, b_q, b_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                valid_q, valid_d, ready_q, ready_d, err_q, err_d;
  logic [3:0]          dig_b;
  logic                dig_err;
  ex_3tobcd u_dec (.X(sh_q[3:0]), .B(dig_b), .err(dig_err));
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: if (in_valid && ready_q) begin
        state_d = CONV;
        sh_d    = in_x;
        cnt_d   = '0;
        b_d     = '0;
        mask_d  = '0;
        ready_d = 1'b0;
      end
      CONV: begin
        b_d[{cnt_q, 2'b00} +: 4] = dig_b;
        mask_d[cnt_q]            = dig_err;
        sh_d                     = sh_q >> 4;
        // the counter parks at zero on the last digit so it never passes DIGITS-1
        if (cnt_q == CW'(DIGITS - 1)) begin
          state_d = DONE;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    err_d = |mask_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      b_q     <= '0;
      mask_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end
  assign in_ready     = ready_q;
  assign out_valid    = valid_q;
  assign out_b        = b_q;
  assign out_err_mask = mask_q;
  assign out_err      = err_q;
endmodule

// File: doc/ex_3tobcd_serial.md
Name: ex_3tobcd_serial

Overview:
Digit-serial Excess-3 to packed-BCD decoder. It is the inverse of the team's BCD-to-Excess-3 converter and sits at the receive end of Excess-3 encoded digit buses. It accepts a multi-digit Excess-3 word over a valid/ready handshake and decodes one digit per clock. It returns the BCD word with per-digit invalid-code flags over a second valid/ready handshake.

Parameters:
DIGITS, 4, number of 4-bit digits per word; legal range 1..16.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_x holds a word to accept
in_ready  output  1  block can accept a word (high only in IDLE)
in_x  input  4*DIGITS  Excess-3 word; digit i is in_x[4i+3:4i], with digit 0 as the LSB
out_valid  output  1  out_b, out_err and out_err_mask are valid
out_ready  input  1  consumer accepts the result
out_b  output  4*DIGITS  decoded BCD word, same digit ordering as in_x
out_err_mask  output  DIGITS  bit i set means digit i was an invalid Excess-3 code
out_err  output  1  OR-reduction of out_err_mask

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, digit counter=0, out_b=0, out_err_mask=0, out_err=0, out_valid=0, in_ready=1 (on the first cycle after reset).
- Per-digit decode (combinational):
  - Valid codes 4'h3..4'hC map to x-3, giving 0..9.
  - Codes 0,1,2,D,E,F are invalid: the BCD digit is forced to 4'hF and the error bit for that digit is set.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture in_x into the input shift register, clear the result register and mask, set counter=0, go to CONV.
- CONV:
  - in_ready=0, out_valid=0.
  - Each cycle: decode digit 0 of the shift register into result digit [counter], set mask[counter] if the code is invalid, shift the input right by 4, increment the counter.
  - After the edge on which counter==DIGITS-1 is decoded, go to DONE.
  - CONV occupies exactly DIGITS cycles.
- DONE:
  - out_valid=1, in_ready=0.
  - out_b, out_err_mask and out_err are held stable while out_ready=0.
  - On out_ready=1: go to IDLE. Outputs keep their last values, but out_valid drops.
- Latency: out_valid rises DIGITS clock edges after the accepting edge.
- Throughput: at most one word per DIGITS+2 cycles. Input and output handshakes never overlap.
- in_valid in CONV or DONE is ignored (in_ready=0). The producer must hold in_x until accepted.
- in_valid while rst=1: not accepted.
- rst mid-CONV or mid-DONE: the word in flight is discarded with no out_valid pulse, and all reset values apply on the next cycle.
- DIGITS=1: CONV lasts exactly one cycle.
- Counter width: $clog2(DIGITS) with a minimum of 1. It never exceeds DIGITS-1 and does not wrap.

Decomposition:
- Shared package (existing converter package, or create ex3_pkg):
  - constant EX3_OFFSET=4'd3
  - constants EX3_MIN=4'h3 and EX3_MAX=4'hC
  - constant BCD_INVALID=4'hF
  - FSM state typedef (IDLE/CONV/DONE)
- Sub-module ex_3tobcd: purely combinational single-digit decoder.
  - Inputs: X[3:0]. Outputs: B[3:0], err.
  - Instantiated once in the datapath and unit-testable exhaustively over all 16 codes.

Test Plan:
- Reset, then DIGITS=4, in_x=16'h4A7C with out_ready=1 -> out_valid rises 4 edges after acceptance; out_b=16'h1749, out_err_mask=4'b0000, out_err=0.
- Bounds: in_x=16'h3333 -> out_b=16'h0000; in_x=16'hCCCC -> out_b=16'h9999; both with no error.
- Invalid codes: in_x=16'h3F53 -> out_b=16'h0F20, out_err_mask=4'b0100, out_err=1. Also in_x=16'h0D21 -> out_b=16'hFFFF, mask=4'b1111.
- Backpressure: complete a word with out_ready=0 for 5 cycles -> out_valid stays 1, out_b is stable, in_ready=0, and a new in_valid is not accepted. Raise out_ready -> IDLE next cycle and in_ready=1.
- Reset mid-operation: assert rst on the 2nd CONV cycle -> next cycle all outputs are at reset values, with no out_valid. A subsequent word 16'h5678 decodes to 16'h2345.
- Back-to-back: in_valid held high with two words, out_ready=1 -> second acceptance exactly DIGITS+2 cycles after the first; both results are correct and in order.
